// File: rtl/uart_tx_param.sv
// UART transmitter with a TX FIFO, programmable baud divider and stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          tx_enable,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          div_q, div_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shr_q, shr_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
    logic                 par_en_q, par_en_d;
`endif

    logic                 push;
    logic                 pop;
    logic                 can_start;
    logic [15:0]          div_eff;
    logic [DATA_BITS-1:0] rd_data;
    logic                 unused_ok;

    assign wr_ready   = (count_q != CW'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready && rst_n;
    assign can_start  = tx_enable && (count_q != '0);
    assign div_eff    = (baud_div < 16'd2) ? 16'd2 : baud_div;
    assign rd_data    = mem[rptr_q];
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_count = count_q;
    assign unused_ok  = ^{parity_mode, (CLK_FREQ > 0)};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shr_d   = shr_q;
        stop2_d = stop2_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
        par_en_d = par_en_q;
`endif
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (can_start) pop = 1'b1;
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = div_q - 16'd1;
                    bit_d   = '0;
                    tx_d    = shr_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                        shr_d = shr_q >> 1;
                        tx_d  = shr_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    state_d = STOP;
                    cnt_d   = div_q - 16'd1;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    if (stop2_q) begin
                        stop2_d = 1'b0;
                        cnt_d   = div_q - 16'd1;
                    end else if (can_start) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame settings are captured with the data so mid-frame input changes are ignored
        if (pop) begin
            state_d = START;
            tx_d    = 1'b0;
            div_d   = div_eff;
            cnt_d   = div_eff - 16'd1;
            shr_d   = rd_data;
            stop2_d = stop_bits;
`ifdef UART_TX_PARITY_EN
            par_en_d = (parity_mode == 2'd1) || (parity_mode == 2'd2);
            par_d    = (parity_mode == 2'd1) ? ~(^rd_data) : ^rd_data;
`endif
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            shr_q    <= '0;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shr_q    <= shr_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
            par_en_q <= par_en_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: table of single frames, FIFO fill/drain,
// tx_enable gating and mid-frame reset, checked against a queue of bytes.
module tb_uart_tx_param;

    localparam int DB    = 8;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_ON = 1;
`else
    localparam int PAR_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   baud_div;
    logic [1:0]    parity_mode;
    logic          stop_bits;
    logic          tx_enable;
    logic [DB-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          tx;
    logic          busy;
    logic [4:0]    fifo_count;

    int errors = 0;
    int checks = 0;
    logic [DB-1:0] sb [$];

    typedef struct {
        logic [7:0]  data;
        logic [15:0] baud;
        logic [1:0]  pm;
        logic        st2;
        int          exp_len;
    } vec_t;

    vec_t vt [7];

    uart_tx_param #(
        .CLK_FREQ  (100_000_000),
        .DATA_BITS (DB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .parity_mode(parity_mode),
        .stop_bits  (stop_bits),
        .tx_enable  (tx_enable),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic push_byte(input logic [DB-1:0] d, input bit acc);
        wr_data  = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        if (acc) sb.push_back(d);
    endtask

    // Waits up to maxw cycles for the start bit, then checks every cycle of the frame
    task automatic check_frame(input int maxw, input int baud, input logic [1:0] pm,
                               input logic st2, output int busy_n, input string name);
        logic [DB-1:0] d;
        logic          eb [$];
        int            dv;
        int            k;
        int            bad;
        bit            first;
        busy_n = 0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s no expected byte queued", name);
            return;
        end
        d  = sb.pop_front();
        dv = (baud < 2) ? 2 : baud;
        eb.push_back(1'b0);
        for (int i = 0; i < DB; i++) eb.push_back(d[i]);
        if (PAR_ON == 1 && pm == 2'd1) eb.push_back(~(^d));
        if (PAR_ON == 1 && pm == 2'd2) eb.push_back(^d);
        eb.push_back(1'b1);
        if (st2) eb.push_back(1'b1);
        k = 0;
        while (tx !== 1'b0 && k < maxw) begin
            tick();
            k++;
        end
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL %s start bit timeout tx=%b exp=0", name, tx);
            return;
        end
        bad   = -1;
        first = 1'b1;
        for (int i = 0; i < eb.size(); i++) begin
            for (int c = 0; c < dv; c++) begin
                if (!first) tick();
                first = 1'b0;
                if (tx !== eb[i] && bad < 0) bad = i;
                if (busy === 1'b1) busy_n++;
            end
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s byte=%h wrong at bit %0d got=%b exp=%b",
                     name, d, bad, ~eb[bad], eb[bad]);
        end
    endtask

    initial begin
        int bn;
        int bad;

        vt[0] = '{8'hA5, 16'd4, 2'd0, 1'b0, 40};
        vt[1] = '{8'h3C, 16'd3, 2'd0, 1'b1, 33};
        vt[2] = '{8'h5A, 16'd0, 2'd0, 1'b0, 20};
        vt[3] = '{8'h07, 16'd2, 2'd2, 1'b0, 20 + 2 * PAR_ON};
        vt[4] = '{8'h07, 16'd2, 2'd1, 1'b0, 20 + 2 * PAR_ON};
        vt[5] = '{8'hFF, 16'd1, 2'd3, 1'b1, 22};
        vt[6] = '{8'h00, 16'd5, 2'd2, 1'b1, 55 + 5 * PAR_ON};

        rst_n       = 1'b0;
        baud_div    = 16'd4;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        tx_enable   = 1'b0;
        wr_data     = '0;
        wr_valid    = 1'b0;
        repeat (3) tick();
        check_int("rst_tx", int'(tx), 1);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_count", int'(fifo_count), 0);
        check_int("rst_wr_ready", int'(wr_ready), 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            baud_div    = vt[i].baud;
            parity_mode = vt[i].pm;
            stop_bits   = vt[i].st2;
            tx_enable   = 1'b1;
            push_byte(vt[i].data, 1'b1);
            check_frame(3, int'(vt[i].baud), vt[i].pm, vt[i].st2, bn,
                        $sformatf("row%0d_wave", i));
            check_int($sformatf("row%0d_busy_len", i), bn, vt[i].exp_len);
            tick();
            check_int($sformatf("row%0d_idle_busy", i), int'(busy), 0);
        end

        tx_enable   = 1'b0;
        baud_div    = 16'd2;
        parity_mode = 2'd0;
        stop_bits   = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i * 37 + 11), 1'b1);
        check_int("full_wr_ready", int'(wr_ready), 0);
        check_int("full_count", int'(fifo_count), DEPTH);
        push_byte(8'hEE, 1'b0);
        check_int("full_17th_count", int'(fifo_count), DEPTH);
        tx_enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check_frame((i == 0) ? 3 : 1, 2, 2'd0, 1'b0, bn,
                        $sformatf("drain%0d_wave", i));
            check_int($sformatf("drain%0d_busy_len", i), bn, 20);
        end
        check_int("drain_count", int'(fifo_count), 0);
        bad = 0;
        repeat (6) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_int("drain_idle_cycles_bad", bad, 0);

        baud_div = 16'd4;
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        tx_enable = 1'b0;
        check_frame(0, 4, 2'd0, 1'b0, bn, "en_off_wave");
        bad = 0;
        repeat (12) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd1) bad++;
        end
        check_int("en_off_hold_bad", bad, 0);
        tx_enable = 1'b1;
        check_frame(3, 4, 2'd0, 1'b0, bn, "en_on_wave");
        check_int("en_on_count", int'(fifo_count), 0);

        for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i), 1'b1);
        repeat (6) tick();
        check_int("mid_busy", int'(busy), 1);
        rst_n    = 1'b0;
        wr_data  = 8'h99;
        wr_valid = 1'b1;
        tick();
        check_int("mrst_tx", int'(tx), 1);
        check_int("mrst_busy", int'(busy), 0);
        check_int("mrst_count", int'(fifo_count), 0);
        check_int("mrst_wr_ready", int'(wr_ready), 1);
        tick();
        check_int("mrst_no_push", int'(fifo_count), 0);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        sb.delete();
        bad = 0;
        repeat (8) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0) bad++;
        end
        check_int("post_rst_idle_bad", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk frequency in Hz (informational; used only by the verification bench).
REQ-002 SHALL have parameter DATA_BITS, default 8, legal 5..9, meaning the data bits per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of 2 and at least 2, meaning the TX FIFO entries.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port baud_div, input, 16 bits: clk cycles per bit.
REQ-007 SHALL have port parity_mode, input, 2 bits: 0 none, 1 odd, 2 even, 3 none.
REQ-008 SHALL have port stop_bits, input, 1 bit: 0 gives one stop bit, 1 gives two.
REQ-009 SHALL have port tx_enable, input, 1 bit: permits starting new frames.
REQ-010 SHALL have port wr_data, input, DATA_BITS wide: byte to enqueue.
REQ-011 SHALL have port wr_valid, input, 1 bit: write request.
REQ-012 SHALL have port wr_ready, output, 1 bit: FIFO not full.
REQ-013 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-016 SHALL perform a push exactly when wr_valid and wr_ready are both 1 on a clk edge; wr_ready SHALL equal (fifo_count != FIFO_DEPTH).
REQ-017 SHALL keep fifo_count unchanged on a simultaneous push and pop; wr_ready is 0 when full, so a push is never accepted while full, even if a pop happens in the same cycle.
REQ-018 SHALL have FIFO pointers that wrap modulo FIFO_DEPTH, and a pop from an empty FIFO SHALL never occur.
REQ-019 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 SHALL pop the FIFO in IDLE when tx_enable=1 and fifo_count>0; the next cycle SHALL enter START with tx=0.
REQ-021 SHALL latch the popped data, parity_mode, stop_bits and baud_div at the pop; input changes mid-frame do not affect the current frame.
REQ-022 SHALL hold each bit for exactly max(baud_div,2) cycles, timed by an internal counter reloaded at every bit boundary.
REQ-023 SHALL send DATA LSB first, DATA_BITS bits.
REQ-024 SHALL, in the DATA state, go next to PARITY when parity is enabled and to STOP otherwise.
REQ-025 SHALL send a PARITY bit equal to XOR(data) for even parity and ~XOR(data) for odd parity.
REQ-026 SHALL hold tx=1 in STOP for 1 or 2 bit times, then return to IDLE.
REQ-027 SHALL allow back-to-back frames: when STOP ends with data available and tx_enable=1, the pop occurs in that cycle and START follows with no idle gap.
REQ-028 SHALL always complete the current frame when tx_enable is deasserted mid-frame; no new frame starts after it.
REQ-029 SHALL drive busy=1 in every state except IDLE.
REQ-030 SHALL register tx as a flop output with no combinational path from the inputs.

Reset
REQ-031 SHALL, with rst_n=0 at a clk edge, set: FSM=IDLE, tx=1, busy=0, FIFO empty (fifo_count=0, wr_ready=1), counters 0.
REQ-032 SHALL, on reset mid-frame, abort the frame and drive tx=1 from the next cycle; queued data is discarded.
REQ-033 SHALL accept no push while rst_n=0.

Configuration
REQ-034 SHALL, with macro UART_TX_PARITY_EN defined, implement parity per REQ-007 and REQ-025.
REQ-035 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and parity logic; parity_mode is ignored and every frame is sent without parity.

Verification
REQ-036 SHALL cover: baud_div=4, no parity, 1 stop, push 8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total, busy=1 throughout.
REQ-037 SHALL cover: UART_TX_PARITY_EN defined, parity_mode=2, baud_div=2, push 8'h07 -> parity bit 1, frame 22 cycles; with parity_mode=1 -> parity bit 0.
REQ-038 SHALL cover: tx_enable=0, push 16 bytes -> wr_ready=0 and fifo_count=16; a 17th wr_valid is not accepted; with tx_enable=1 all 16 bytes go out in order with no idle gap.
REQ-039 SHALL cover: stop_bits=1, baud_div=3 -> stop high lasts 6 cycles; baud_div=0 -> 2 cycles per bit.
REQ-040 SHALL cover: rst_n=0 during the DATA state with 3 bytes queued -> tx=1 next cycle, fifo_count=0, busy=0, wr_ready=1.
REQ-041 SHALL cover: tx_enable deasserted in the middle of START -> the frame completes, then tx stays 1 and fifo_count stays unchanged.
